stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- 1-to-4 valid/ready stream demultiplexer; the distribution-side counterpart of the 4-to-1 select mux in the comb microbenchmark set.
- Steers each accepted input beat to one of four output channels chosen by a 2-bit select.
- Each channel has a one-entry registered holding slot, so the outputs are registered and back-pressure is handled per channel.
- Serves as a sequential companion benchmark and as a reusable fan-out stage.

Parameters:
- BW, 8, data width of each beat in bits (≥1).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept the beat this cycle.
- in_data  input  BW  input beat payload.
- sel  input  2  destination channel (0..3); qualified by in_valid.
- out_valid  output  4  bit i: channel i slot holds a beat.
- out_ready  input  4  bit i: channel i consumer accepts this cycle.
- out_data  output  4*BW  channel i payload in bits [i*BW +: BW].

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: while rst is high at a clock edge, all out_valid bits clear to 0 and all out_data clears to 0. in_ready is combinational and may be 1 during reset, but no beat is captured on a reset edge. Reset mid-operation discards all held beats.
- Per-channel slot state: EMPTY (valid=0) or FULL (valid=1). Channel i drains when out_valid[i] & out_ready[i].
- in_ready = ~out_valid[sel] | out_ready[sel]. It is combinational from sel, out_valid and out_ready only, never from in_valid.
- Transfer: in_valid & in_ready at an edge loads in_data into slot[sel] and sets out_valid[sel]=1. Output is visible the next cycle (latency 1 cycle).
- Transitions for slot i, where acc = transfer with sel==i and drn = out_valid[i] & out_ready[i]:
  - EMPTY + acc → FULL.
  - FULL + drn + !acc → EMPTY.
  - FULL + drn + acc → FULL with new data (same-cycle replace; full throughput of 1 beat/cycle per channel).
  - FULL + !drn → FULL, data held, in_ready=0 for beats targeting i.
- Channels are independent. A stalled channel never blocks beats to other channels; head-of-line blocking applies only to the current input beat.
- Upstream must hold in_data and sel stable while in_valid=1 and in_ready=0. Behaviour is undefined otherwise.
- out_data[i] holds its last value after draining; it is not cleared.
- Ordering: beats to the same channel leave in acceptance order.

Optional Feature:
- Macro: STREAM_DEMUX_STATS_EN.
- Defined: adds output port beat_count (4*16 bits). Counter i is a 16-bit saturating count of beats accepted into channel i.
  - Increments on every transfer with sel==i.
  - Holds at 16'hFFFF; never wraps.
  - Cleared by rst.
- Undefined: port and counters are absent; functional behaviour is otherwise identical.

Decomposition:
- Package stream_demux_pkg holds:
  - NUM_CH=4 and SEL_W=2.
  - typedef logic [SEL_W-1:0] ch_sel_t.
  - CNT_W=16 and CNT_MAX.
- One natural sub-module, demux_slot: a one-entry register slice with load/valid/ready and BW-wide data, instantiated four times via generate.
- The top handles select decode, in_ready mux and the optional counters.

Test Plan (BW=8):
- Reset: assert rst 2 cycles with in_valid=1, sel=0, in_data=8'hAA → out_valid=4'b0000 and out_data all 0 during and after reset; no capture.
- Basic steer: all out_ready=1; send 8'h11,8'h22,8'h33,8'h44 with sel=0,1,2,3 back-to-back → each channel i asserts out_valid[i] for one cycle, the cycle after its beat, with the matching data; in_ready stays 1.
- Back-pressure: out_ready[2]=0; send 8'h5A sel=2, then 8'h5B sel=2 → first beat held; in_ready=0 on second beat until out_ready[2]=1. Then 8'h5A drains and 8'h5B loads in the same cycle (valid stays 1).
- Channel independence: channel 1 stalled full; send sel=3 data 8'hC3 → accepted immediately, out_valid[3]=1 next cycle; channel 1 unchanged.
- Reset mid-operation: channels 0 and 2 full and stalled; pulse rst one cycle → out_valid=0000; next beat 8'h77 sel=0 accepted normally.
- STATS_EN: 65540 beats to sel=1 with out_ready=1 → beat_count[1]=16'hFFFF (saturated), others 0; rst → all counts 0.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  typedef logic [SEL_W-1:0] ch_sel_t;
  localparam int CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
endpackage

// File: rtl/stream_demux_slot.sv
// One-entry registered holding slot; a load may coincide with a drain,
// which replaces the held beat without a bubble.
module demux_slot #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [BW-1:0] in_data,
  output logic          valid,
  input  logic          ready,
  output logic [BW-1:0] data
);

  // Slot occupancy and payload; data is kept after a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= {BW{1'b0}};
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// 1-to-4 valid/ready stream demultiplexer with per-channel registered slots.
// Optional per-channel saturating beat counters under STREAM_DEMUX_STATS_EN.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BW-1:0]        in_data,
  input  ch_sel_t              sel,
  output logic [NUM_CH-1:0]    out_valid,
  input  logic [NUM_CH-1:0]    out_ready,
  output logic [NUM_CH*BW-1:0] out_data
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] beat_count
`endif
);

  logic [NUM_CH-1:0] load;

  // Only the selected channel gates acceptance, so a stalled slot never blocks others.
  assign in_ready = ~out_valid[sel] | out_ready[sel];

  // One-hot load strobe for the destination slot of an accepted beat.
  always_comb begin
    load = {NUM_CH{1'b0}};
    if (in_valid && in_ready) begin
      load[sel] = 1'b1;
    end else begin
      load = {NUM_CH{1'b0}};
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(.BW(BW)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (load[i]),
      .in_data (in_data),
      .valid   (out_valid[i]),
      .ready   (out_ready[i]),
      .data    (out_data[i*BW +: BW])
    );
  end

`ifdef STREAM_DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt [NUM_CH];

  // Saturating count of beats accepted per channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    assign beat_count[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed vector table, randomized traffic against a
// queue-based reference, and the saturating counters when STREAM_DEMUX_STATS_EN is set.
module tb_stream_demux;
  import stream_demux_pkg::*;

  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic [1:0]  sel = 2'd0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'h0;
  logic [31:0] out_data;
`ifdef STREAM_DEMUX_STATS_EN
  logic [63:0] beat_count;
`endif

  stream_demux #(.BW(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .beat_count(beat_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: each channel is a FIFO of held beats plus the last payload shown.
  logic [7:0] q [4][$];
  logic [7:0] last_data [4];

  typedef struct {
    logic       r;
    logic       iv;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] o;
    logic       x_rdy;
    logic [3:0] x_vld;
    logic [1:0] ch;
    logic [7:0] x_dat;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_cycle(input logic r, input logic iv, input logic [1:0] s,
                          input logic [7:0] d, input logic [3:0] o, output logic rdy_seen);
    logic       exp_rdy;
    logic [3:0] ev;
    logic [31:0] ed;
    @(negedge clk);
    rst = r; in_valid = iv; sel = s; in_data = d; out_ready = o;
    #1;
    exp_rdy  = (q[s].size() == 0) || o[s];
    rdy_seen = in_ready;
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        q[i].delete();
        last_data[i] = 8'h00;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (q[i].size() != 0 && o[i]) void'(q[i].pop_front());
      end
      if (iv && exp_rdy) begin
        q[s].push_back(d);
        last_data[s] = d;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      ev[i] = (q[i].size() != 0);
      ed[i*8 +: 8] = last_data[i];
    end
    check("out_valid", {60'd0, out_valid}, {60'd0, ev});
    check("out_data", {32'd0, out_data}, {32'd0, ed});
  endtask

  initial begin
    logic       rdy;
    logic       stall;
    logic       riv;
    logic       rr;
    logic [1:0] rs;
    logic [7:0] rd;
    logic [3:0] ro;

    for (int i = 0; i < 4; i++) last_data[i] = 8'h00;

    //             r     iv    sel   data   ordy  rdy   vld   ch    data
    tbl[0]  = '{1'b1, 1'b1, 2'd0, 8'hAA, 4'hF, 1'b1, 4'h0, 2'd0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 2'd0, 8'hAA, 4'hF, 1'b1, 4'h0, 2'd0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 2'd0, 8'h11, 4'hF, 1'b1, 4'h1, 2'd0, 8'h11};
    tbl[3]  = '{1'b0, 1'b1, 2'd1, 8'h22, 4'hF, 1'b1, 4'h2, 2'd1, 8'h22};
    tbl[4]  = '{1'b0, 1'b1, 2'd2, 8'h33, 4'hF, 1'b1, 4'h4, 2'd2, 8'h33};
    tbl[5]  = '{1'b0, 1'b1, 2'd3, 8'h44, 4'hF, 1'b1, 4'h8, 2'd3, 8'h44};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'h0, 2'd3, 8'h44};
    tbl[7]  = '{1'b0, 1'b1, 2'd2, 8'h5A, 4'hB, 1'b1, 4'h4, 2'd2, 8'h5A};
    tbl[8]  = '{1'b0, 1'b1, 2'd2, 8'h5B, 4'hB, 1'b0, 4'h4, 2'd2, 8'h5A};
    tbl[9]  = '{1'b0, 1'b1, 2'd2, 8'h5B, 4'hB, 1'b0, 4'h4, 2'd2, 8'h5A};
    tbl[10] = '{1'b0, 1'b1, 2'd2, 8'h5B, 4'hF, 1'b1, 4'h4, 2'd2, 8'h5B};
    tbl[11] = '{1'b0, 1'b0, 2'd2, 8'h5B, 4'hF, 1'b1, 4'h0, 2'd2, 8'h5B};
    tbl[12] = '{1'b0, 1'b1, 2'd1, 8'hB1, 4'hD, 1'b1, 4'h2, 2'd1, 8'hB1};
    tbl[13] = '{1'b0, 1'b1, 2'd3, 8'hC3, 4'hD, 1'b1, 4'hA, 2'd3, 8'hC3};
    tbl[14] = '{1'b0, 1'b0, 2'd1, 8'h00, 4'h5, 1'b0, 4'hA, 2'd1, 8'hB1};
    tbl[15] = '{1'b0, 1'b1, 2'd0, 8'hE0, 4'h0, 1'b1, 4'hB, 2'd0, 8'hE0};
    tbl[16] = '{1'b0, 1'b1, 2'd2, 8'hE2, 4'h0, 1'b1, 4'hF, 2'd2, 8'hE2};
    tbl[17] = '{1'b1, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 4'h0, 2'd0, 8'h00};
    tbl[18] = '{1'b0, 1'b1, 2'd0, 8'h77, 4'h0, 1'b1, 4'h1, 2'd0, 8'h77};
    tbl[19] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'h0, 2'd0, 8'h77};

    // Bring the slots out of their power-up unknown state before checking.
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 20; k++) begin
      do_cycle(tbl[k].r, tbl[k].iv, tbl[k].s, tbl[k].d, tbl[k].o, rdy);
      check($sformatf("vec%0d_ready", k), {63'd0, rdy}, {63'd0, tbl[k].x_rdy});
      check($sformatf("vec%0d_valid", k), {60'd0, out_valid}, {60'd0, tbl[k].x_vld});
      check($sformatf("vec%0d_data", k), {56'd0, out_data[tbl[k].ch*8 +: 8]}, {56'd0, tbl[k].x_dat});
    end

    // Random traffic; a refused beat is held stable until accepted.
    stall = 1'b0;
    riv = 1'b0; rs = 2'd0; rd = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      rr = ($urandom_range(0, 63) == 0);
      if (!stall) begin
        riv = ($urandom_range(0, 3) != 0);
        rs  = 2'($urandom_range(0, 3));
        rd  = 8'($urandom_range(0, 255));
      end
      ro = 4'($urandom_range(0, 15));
      do_cycle(rr, riv, rs, rd, ro, rdy);
      stall = riv && !rdy && !rr;
    end

`ifdef STREAM_DEMUX_STATS_EN
    do_cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'hF, rdy);
    check("cnt_after_rst", beat_count, 64'd0);
    for (int n = 0; n < 65540; n++) begin
      do_cycle(1'b0, 1'b1, 2'd1, 8'(n), 4'hF, rdy);
      if (n == 99) check("cnt_100", beat_count, {32'd0, 16'd100, 16'd0});
    end
    check("cnt_saturated", beat_count, {32'd0, 16'hFFFF, 16'd0});
    do_cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'hF, rdy);
    check("cnt_cleared", beat_count, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
